ps2_rx: RTL and testbench
=========================

# ps2_rx

Receive-only PS/2 keyboard front end for the DE1-SoC top level. It synchronises and de-glitches the PS2_CLK/PS2_DAT lines and deserialises 11-bit device-to-host frames. Good bytes go into a small FIFO, which presents them downstream on a valid/ready interface for scan-code decoding and display logic. The top level leaves both PS/2 pins undriven (high-Z) and feeds their input values here.

## Interface
- CLK_HZ, 50_000_000: frequency of CLOCK_50.
- FILTER_LEN, 8: consecutive equal samples required before a filtered line changes; range 2–255.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- TIMEOUT_US, 2000: frame watchdog in microseconds; used only with the watchdog macro.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  reset, asynchronous assert, active-low; top level drives it from KEY[0].
- ps2_clk_i  in  1  raw PS2_CLK pin value, asynchronous.
- ps2_dat_i  in  1  raw PS2_DAT pin value, asynchronous.
- data_o  out  8  byte at the FIFO head.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- parity_err_o  out  1  one-cycle pulse: frame dropped, odd parity failed.
- frame_err_o  out  1  one-cycle pulse: frame dropped for bad stop bit or watchdog expiry.
- overflow_o  out  1  one-cycle pulse: good frame dropped because the FIFO was full.
- busy_o  out  1  FSM not in IDLE.

## Operation
- **Input conditioning:** each raw input passes through a 2-FF synchroniser and then a saturating filter. The filtered value flips only after FILTER_LEN consecutive samples that differ from it.
- **Edge detect:** a sampling event (`fall`) is a one-cycle strobe on a 1→0 transition of the filtered clock.
- **FSM, advancing only on `fall`:**
  - IDLE: if filtered data is 0 (start bit), go to DATA with bit count 0. If it is 1, stay in IDLE.
  - DATA: shift in filtered data, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: if stop bit is 0, pulse frame_err_o. Otherwise, if the XOR of the 8 data bits and the parity bit is 0, pulse parity_err_o. Otherwise the frame is good: push it into the FIFO, or pulse overflow_o if the FIFO is full. In every case return to IDLE.
- **Error priority:** stop error over parity error over overflow. At most one error pulse fires per frame.
- **FIFO:** push happens in the cycle after the stop-bit `fall`; pop happens on valid_o && ready_i.
  - Full FIFO with a pop in the push cycle: the push is accepted and no overflow is flagged.
  - Empty FIFO: no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit.
- **Reset:** applies at any point, including mid-frame.
  - State returns to IDLE and the FIFO empties.
  - Filtered lines and synchronisers go to 1.
  - data_o, valid_o, busy_o and all error pulses go to 0.

## Timing
- A raw PS2_CLK fall produces `fall` 2 + FILTER_LEN cycles later.
- valid_o rises 2 cycles after the stop-bit `fall`: 1 cycle for the push, 1 cycle for the registered flag.
- data_o is stable while valid_o && !ready_i.
- Each pop advances the FIFO head on the next cycle. Back-to-back pops are allowed: throughput is 1 byte/cycle.
- Error pulses assert in the cycle after the stop-bit `fall` (or after watchdog expiry) and last exactly 1 cycle.
- At 50 MHz the PS/2 bit period is 60–100 µs, so FILTER_LEN ≤ 255 leaves ample margin.

## Configuration
- **PS2_RX_WATCHDOG_EN defined:**
  - A counter runs while busy_o is high and clears on every `fall`.
  - At CLK_HZ/1_000_000 × TIMEOUT_US cycles, the FSM forces IDLE, discards the partial frame and pulses frame_err_o.
- **PS2_RX_WATCHDOG_EN undefined:** no counter exists. A stalled partial frame holds busy_o high until the remaining edges arrive or reset asserts.

## Structure
- **Package ps2_pkg:**
  - state enum (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_BITS = 8;
  - odd-parity check function.
- **Sub-module ps2_rx_fifo:** synchronous FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty/head. Filter, edge detect and FSM stay in ps2_rx.

## Test plan
- Default parameters, ready_i = 1. Send 0x1C with parity bit 0 and stop bit 1 → one valid_o beat with data_o = 0x1C, 2 cycles after the stop `fall`; no error pulses.
- Send 0xF0 with parity bit 0, which is wrong because 0xF0 needs parity 1 → no valid_o; parity_err_o pulses exactly 1 cycle.
- ready_i = 0; send 0x01–0x05 → valid_o held with data_o = 0x01, and overflow_o pulses on the 5th frame. Raise ready_i → drains 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then valid_o = 0.
- Mid-frame, hold ps2_clk_i low for 3 cycles (< FILTER_LEN) → no `fall`, bit count unchanged; the frame 0x5A still decodes correctly.
- With PS2_RX_WATCHDOG_EN: send a start bit plus 3 data bits, then stall 3 ms → frame_err_o pulse and busy_o = 0; the next frame 0x29 is received correctly. Without the macro, the same stall keeps busy_o = 1.
- Assert resetn low after 5 bits of a frame, then release → all outputs 0 and FIFO empty; the following frame 0x76 is received cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, constants and the parity check for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
  localparam int PS2_DATA_BITS = 8;
  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous FIFO for received bytes
// Ports: clk/rst_n (async active-low), push+din write, pop read, full/empty flags, head = oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    head = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver - synchronise, de-glitch, deserialise 11-bit frames into a FIFO
// Ports: CLOCK_50, resetn (async active-low), ps2_clk_i/ps2_dat_i raw pins,
//   data_o/valid_o/ready_i output stream, parity_err_o/frame_err_o/overflow_o one-cycle pulses, busy_o.
// Build option: define PS2_RX_WATCHDOG_EN to abort frames stalled for TIMEOUT_US.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);
  if (FILTER_LEN < 2 || FILTER_LEN > 255 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CLK_HZ < 1_000_000 || TIMEOUT_US < 1) begin : g_bad_param
    $error("ps2_rx: parameter out of range");
  end
  localparam logic [7:0] FL_M1 = 8'(FILTER_LEN - 1);
  // index 0 = PS/2 clock, index 1 = PS/2 data
  logic [1:0] s1_q, s2_q, filt_q, filt_d;
  logic [7:0] fcnt_q [2];
  logic [7:0] fcnt_d [2];
  logic fall_q, fall_d;
  state_e state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d, head;
  logic par_q, par_d, push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
  logic full, empty, pop;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = (s2_q[i] != filt_q[i]) ? fcnt_q[i] + 8'd1 : 8'd0;
      filt_d[i] = filt_q[i];
      if (s2_q[i] != filt_q[i] && fcnt_q[i] == FL_M1) begin
        filt_d[i] = s2_q[i];
        fcnt_d[i] = 8'd0;
      end
    end
    fall_d = filt_q[0] && !filt_d[0];
  end
`ifdef PS2_RX_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(CLK_HZ / 1_000_000 * TIMEOUT_US - 1);
  logic [31:0] wd_q, wd_d;
  logic wd_expired;
  always_comb begin
    wd_d = (fall_q || state_q == IDLE) ? 32'd0 : wd_q + 32'd1;
    wd_expired = state_q != IDLE && !fall_q && wd_q == WD_LAST;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) wd_q <= '0;
    else wd_q <= wd_expired ? 32'd0 : wd_d;
`else
  logic wd_expired;
  assign wd_expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    par_d = par_q;
    push_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    if (fall_q)
      case (state_q)
        IDLE: begin
          state_d = filt_q[1] ? IDLE : DATA;
          bcnt_d = 3'd0;
        end
        DATA: begin
          shift_d = {filt_q[1], shift_q[PS2_DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 3'd1;
          state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = filt_q[1];
          state_d = STOP;
        end
        default: begin
          ferr_d = !filt_q[1];
          perr_d = filt_q[1] && !odd_parity_ok(shift_q, par_q);
          push_d = filt_q[1] && odd_parity_ok(shift_q, par_q);
          state_d = IDLE;
        end
      endcase
    if (wd_expired) begin
      state_d = IDLE;
      ferr_d = 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      filt_q <= 2'b11;
      fcnt_q <= '{8'd0, 8'd0};
      fall_q <= 1'b0;
      state_q <= IDLE;
      bcnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q <= {ps2_dat_i, ps2_clk_i};
      s2_q <= s1_q;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      push_q <= push_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  ps2_rx_fifo #(.WIDTH(PS2_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK_50),
    .rst_n(resetn),
    .push(push_q),
    .din(shift_q),
    .pop(pop),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_comb begin
    valid_o = !empty;
    pop = valid_o && ready_i;
    data_o = empty ? 8'd0 : head;
    overflow_o = push_q && full && !pop;
    parity_err_o = perr_q;
    frame_err_o = ferr_q;
    busy_o = state_q != IDLE;
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed bench for ps2_rx
module tb_ps2_rx;
  localparam int H = 20;
  logic clk = 1'b0, resetn = 1'b0, pc = 1'b1, pd = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic valid, perr, ferr, ovf, busy;
  int tests = 0, fails = 0, ferr_cnt = 0, ferr_base = 0;

  ps2_rx #(.TIMEOUT_US(20)) dut (
    .CLOCK_50(clk), .resetn(resetn), .ps2_clk_i(pc), .ps2_dat_i(pd),
    .data_o(data), .valid_o(valid), .ready_i(ready),
    .parity_err_o(perr), .frame_err_o(ferr), .overflow_o(ovf), .busy_o(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) if (ferr) ferr_cnt <= ferr_cnt + 1;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one PS/2 bit: data set while clock high, then clock falls; 'last' leaves the clock low
  task automatic bit_out(input logic b, input logic glitch, input logic last);
    pd = b;
    repeat (H) @(negedge clk);
    if (glitch) begin
      pc = 1'b0;
      repeat (3) @(negedge clk);
      pc = 1'b1;
      repeat (H) @(negedge clk);
    end
    pc = 1'b0;
    if (!last) begin
      repeat (H) @(negedge clk);
      pc = 1'b1;
    end
  endtask

  // returns on the negedge where the stop-bit clock fall is driven
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) bit_out(f[i], i == glitch_bit, i == 10);
  endtask

  task automatic partial(input logic [7:0] d, input int n);
    logic [10:0] f;
    f = {1'b1, odd_par(d), d, 1'b0};
    for (int i = 0; i < n; i++) bit_out(f[i], 1'b0, 1'b0);
    pd = 1'b1;
  endtask

  task automatic release_clk();
    repeat (H) @(negedge clk);
    pc = 1'b1;
    pd = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] d);
    ready = 1'b0;
    send_frame(d, odd_par(d), 1'b1, -1);
    release_clk();
    chk1({tag, "_valid"}, valid, 1'b1);
    chk8({tag, "_data"}, data, d);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk1({tag, "_popped"}, valid, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_valid", valid, 1'b0);
    chk8("rst_data", data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_perr", perr, 1'b0);
    chk1("rst_ferr", ferr, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    // good byte 0x1C, timing of valid relative to the stop-bit fall
    ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    repeat (11) @(posedge clk);
    #1;
    chk1("t1_valid_early", valid, 1'b0);
    chk1("t1_busy_idle", busy, 1'b0);
    chk1("t1_perr", perr, 1'b0);
    chk1("t1_ferr", ferr, 1'b0);
    @(posedge clk);
    #1;
    chk1("t1_valid", valid, 1'b1);
    chk8("t1_data", data, 8'h1C);
    @(posedge clk);
    #1;
    chk1("t1_one_beat", valid, 1'b0);
    release_clk();
    // parity error on 0xF0 with parity bit 0
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    repeat (11) @(posedge clk);
    #1;
    chk1("t2_perr", perr, 1'b1);
    chk1("t2_ferr", ferr, 1'b0);
    @(posedge clk);
    #1;
    chk1("t2_perr_end", perr, 1'b0);
    chk1("t2_no_valid", valid, 1'b0);
    release_clk();
    // bad stop bit wins over everything
    send_frame(8'h55, 1'b1, 1'b0, -1);
    repeat (11) @(posedge clk);
    #1;
    chk1("t3_ferr", ferr, 1'b1);
    chk1("t3_perr", perr, 1'b0);
    @(posedge clk);
    #1;
    chk1("t3_ferr_end", ferr, 1'b0);
    chk1("t3_no_valid", valid, 1'b0);
    release_clk();
    // fill FIFO with ready low, overflow on fifth frame
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_frame(8'(k), odd_par(8'(k)), 1'b1, -1);
      release_clk();
    end
    chk1("t4_full_valid", valid, 1'b1);
    send_frame(8'h05, 1'b1, 1'b1, -1);
    repeat (11) @(posedge clk);
    #1;
    chk1("t4_ovf", ovf, 1'b1);
    chk1("t4_ovf_perr", perr, 1'b0);
    @(posedge clk);
    #1;
    chk1("t4_ovf_end", ovf, 1'b0);
    release_clk();
    chk1("t4_held_valid", valid, 1'b1);
    chk8("t4_held_data", data, 8'h01);
    ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk1("t4_drain_valid", valid, 1'b1);
      chk8("t4_drain_data", data, 8'(k));
    end
    @(posedge clk);
    #1;
    chk1("t4_drained", valid, 1'b0);
    @(negedge clk);
    // short clock glitch mid-frame must be ignored
    ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1, 4);
    release_clk();
    chk1("t5_valid", valid, 1'b1);
    chk8("t5_data", data, 8'h5A);
    chk1("t5_perr", perr, 1'b0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk1("t5_popped", valid, 1'b0);
    // stalled partial frame
    ferr_base = ferr_cnt;
    partial(8'h0B, 4);
    chk1("t6_busy_mid", busy, 1'b1);
    repeat (2000) @(negedge clk);
`ifdef PS2_RX_WATCHDOG_EN
    chkint("t6_wd_pulses", ferr_cnt - ferr_base, 1);
    chk1("t6_wd_idle", busy, 1'b0);
`else
    chkint("t6_no_wd_pulses", ferr_cnt - ferr_base, 0);
    chk1("t6_stalled_busy", busy, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
`endif
    good_frame("t6_after", 8'h29);
    // reset mid-frame with a byte waiting in the FIFO
    send_frame(8'h11, odd_par(8'h11), 1'b1, -1);
    release_clk();
    chk1("t7_pre_valid", valid, 1'b1);
    partial(8'h6B, 5);
    chk1("t7_pre_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("t7_rst_valid", valid, 1'b0);
    chk8("t7_rst_data", data, 8'h00);
    chk1("t7_rst_busy", busy, 1'b0);
    chk1("t7_rst_errs", perr | ferr | ovf, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk1("t7_empty", valid, 1'b0);
    good_frame("t7_after", 8'h76);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
